// File: rtl/dmem_clk_ram_if.sv
// dmem_clk_ram_if: MEM-stage data-memory bus between the CPU pipeline
// (master) and the clocked data RAM (slave).
interface dmem_clk_ram_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q;
    logic              locked;

    modport master (output address, data, wren, input  q, locked);
    modport slave  (input  address, data, wren, output q, locked);
endinterface

// File: rtl/dmem_clk_ram.sv
// dmem_clk_ram: data memory for the MEM stage. A behavioural clock-lock
// model holds the block off for LOCK_CYCLES edges after reset, then the
// array is zeroed one word per cycle, then the RAM serves single-port
// synchronous reads (latency 1) and writes.
// Build option: define WRITE_FIRST_EN to make a same-cycle write visible on
// q at the next cycle; otherwise reads return the old word (read-first).
module dmem_clk_ram #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int LOCK_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_clk_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {LOCK, CLEAR, READY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   lock_cnt;
    logic [ADDR_W-1:0]  clr_ptr;
    logic [DATA_W-1:0]  q_r;
    logic               locked_r;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  rd_word;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Next-state and memory port muxing: the clear sequencer owns the write
    // port during CLEAR, the CPU bus owns it only once READY.
    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_addr  = bus.address;
        mem_wdata = bus.data;
        unique case (state_q)
            LOCK: begin
                if (lock_cnt == LOCK_LAST) state_d = CLEAR;
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_ptr;
                mem_wdata = '0;
                if (clr_ptr == {ADDR_W{1'b1}}) state_d = READY;
            end
            READY: begin
                mem_we = bus.wren;
            end
            default: state_d = LOCK;
        endcase
    end

    // Read data selection: old word unless write-first forwarding is built in.
    always_comb begin
`ifdef WRITE_FIRST_EN
        rd_word = bus.wren ? bus.data : mem[bus.address];
`else
        rd_word = mem[bus.address];
`endif
    end

    // FSM state, lock counter, clear pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOCK;
            lock_cnt <= '0;
            clr_ptr  <= '0;
            q_r      <= '0;
            locked_r <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_r <= (state_d == READY);
            if (state_q == LOCK)  lock_cnt <= lock_cnt + CNT_W'(1);
            if (state_q == CLEAR) clr_ptr  <= clr_ptr + ADDR_W'(1);
            q_r <= (state_q == READY) ? rd_word : '0;
        end
    end

    // Array write port; contents are not reset, the CLEAR pass zeroes them.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign bus.q      = q_r;
    assign bus.locked = locked_r;
endmodule

// File: tb/tb_dmem_clk_ram.sv
// tb_dmem_clk_ram: scoreboard bench for dmem_clk_ram. Stimulus pushes the
// expected q for each access; a negedge monitor pops and compares.
module tb_dmem_clk_ram;
    localparam int TOTAL_LOCK = 16 + 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_clk_ram_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_clk_ram #(.ADDR_W(8), .DATA_W(32), .LOCK_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];
    logic        chk_next = 1'b0;
    logic        chk_d    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: one cycle after an access was presented, q must match.
    always @(posedge clk) chk_d <= chk_next;
    always @(negedge clk) begin
        if (chk_d) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("q_rd", bus.q, exp_q.pop_front());
        end
    end

    task automatic access(input logic [7:0] a, input logic [31:0] d, input logic we);
        logic [31:0] e;
        @(negedge clk);
        bus.address = a;
        bus.data    = d;
        bus.wren    = we;
        chk_next    = 1'b1;
`ifdef WRITE_FIRST_EN
        e = we ? d : ref_mem[a];
`else
        e = ref_mem[a];
`endif
        exp_q.push_back(e);
        if (we) ref_mem[a] = d;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.wren = 1'b0;
        chk_next = 1'b0;
    endtask

    task automatic wait_lock(input string nm);
        int n;
        n = 0;
        while (bus.locked !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, bus.locked}, 32'd1);
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = '0;
        bus.address = 8'h05;
        bus.data    = 32'hAAAA_AAAA;
        bus.wren    = 1'b1;

        // Reset held for 3 cycles; outputs must already be cleared.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q", bus.q, 32'd0);
        chk("rst_locked", {31'd0, bus.locked}, 32'd0);
        rst_n = 1'b1;

        // Lock window: wren held high at 0x05 throughout must be ignored.
        for (int k = 1; k <= TOTAL_LOCK; k++) begin
            @(negedge clk);
            if (k == 1 || k == 16 || k == 17 || k >= TOTAL_LOCK - 1 || (k % 37) == 0) begin
                chk($sformatf("lock_locked_%0d", k), {31'd0, bus.locked},
                    (k >= TOTAL_LOCK) ? 32'd1 : 32'd0);
                chk($sformatf("lock_q_%0d", k), bus.q, 32'd0);
            end
            if (k == TOTAL_LOCK) bus.wren = 1'b0;
        end

        // Cleared contents, including the address hammered during CLEAR.
        access(8'h00, 32'h0, 1'b0);
        access(8'h7F, 32'h0, 1'b0);
        access(8'hFF, 32'h0, 1'b0);
        access(8'h05, 32'h0, 1'b0);

        // Directed write/read.
        access(8'h10, 32'hDEAD_BEEF, 1'b1);
        access(8'hFF, 32'h1234_5678, 1'b1);
        access(8'h10, 32'h0, 1'b0);
        access(8'hFF, 32'h0, 1'b0);

        // Same-address overwrite, then readback.
        access(8'h20, 32'h1111_1111, 1'b1);
        access(8'h20, 32'h2222_2222, 1'b1);
        access(8'h20, 32'h0, 1'b0);

        // Random traffic, addresses biased toward a small window for reuse.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 15));
            access(a, $urandom, 1'($urandom_range(0, 1)));
        end

        // Mid-operation reset between edges.
        access(8'h03, 32'h0000_0055, 1'b1);
        access(8'h03, 32'h0, 1'b0);
        idle();
        @(posedge clk);
        chk("pre_rst_q", bus.q, 32'h0000_0055);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", bus.q, 32'd0);
        chk("async_rst_locked", {31'd0, bus.locked}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        wait_lock("relock");
        access(8'h03, 32'h0, 1'b0);
        access(8'h10, 32'h0, 1'b0);
        idle();
        idle();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
